bus_mem_ctrl: RTL and testbench
===============================

// Module: bus_mem_ctrl
// PURPOSE
//  Data-memory slave directly downstream of the cpu bus (ADDR, Data_BUS_WRITE, CS, WR_RD -> Data_BUS_READ).
//  Holds a word-addressed RAM plus one memory-mapped output register, and inserts programmable wait states.
//  Runs on the fast CLK. The cpu runs on CLK_SYS = CLK/34 and holds its bus signals for many CLK cycles,
//  so every access completes well inside one CLK_SYS period.
// PARAMETERS
//  ADDR_WIDTH   10             RAM word-address bits (2**ADDR_WIDTH words of 32 bits)
//  WAIT_CYCLES  2              wait states before the array access; legal range 0..30
//  IO_BASE      32'hFFFF_FF00  byte address of the IO_OUT register
// PORTS
//  CLK             in   1   system clock (50 MHz); the only clock
//  RST             in   1   asynchronous reset, active-low
//  CS              in   1   chip select from the cpu
//  WR_RD           in   1   1 = write, 0 = read
//  ADDR            in   32  byte address from the cpu
//  Data_BUS_WRITE  in   32  write data from the cpu
//  Data_BUS_READ   out  32  read data to the cpu; registered and held until the next read completes
//  BUSY            out  1   high while the FSM is outside IDLE
//  DONE            out  1   one-cycle pulse when an access completes
//  ERR             out  1   fault flag for the last completed access
//  IO_OUT          out  32  memory-mapped output register
// BEHAVIOUR
//  Reset (RST=0, asynchronous):
//   - FSM goes to IDLE.
//   - Data_BUS_READ = 0, BUSY = 0, DONE = 0, ERR = 0, IO_OUT = 0.
//   - RAM contents are not reset.
//   - Reset in any state aborts the access; a write is never committed unless ACCESS has already completed.
//  Request acceptance: in IDLE, a request is accepted when CS=1 and either
//   - CS was 0 on the previous cycle, or
//   - {ADDR, WR_RD} differs from the last accepted request.
//   On acceptance, ADDR, WR_RD and Data_BUS_WRITE are latched. CS held high with an unchanged bus
//   does not retrigger.
//  FSM states: IDLE -> WAIT -> ACCESS -> DONE_ST -> IDLE.
//   - WAIT lasts WAIT_CYCLES cycles (skipped when WAIT_CYCLES = 0).
//   - ACCESS and DONE_ST last one cycle each.
//  Decode (performed in ACCESS):
//   - Misaligned: ADDR[1:0] != 0 -> fault.
//   - IO: ADDR == IO_BASE -> a write loads IO_OUT; a read returns IO_OUT.
//   - RAM: ADDR < 4*2**ADDR_WIDTH -> word index is ADDR[ADDR_WIDTH+1:2].
//   - Anything else -> fault.
//   - Fault: no state change; a faulted read returns 32'h0000_0000.
//  Completion (in DONE_ST):
//   - DONE = 1.
//   - ERR is set to the fault status of this access and held until the next completion.
//   - Data_BUS_READ is updated only on completed reads; writes leave it unchanged.
//  Latency: cycle 0 is the acceptance edge. DONE is high, and read data is valid, in cycle WAIT_CYCLES+2.
//   BUSY is high in cycles 1..WAIT_CYCLES+2.
//  CS falls during WAIT: abort to IDLE. No write is committed, no DONE pulse, ERR is unchanged.
//  CS falls during ACCESS or DONE_ST: the access still completes normally.
//  A bus change during BUSY is ignored. It is evaluated once the FSM returns to IDLE.
// TESTING
//  1 Write 32'hCAFE_0001 to ADDR 0x10, then read 0x10.
//    -> DONE pulses at cycle 4 (WAIT_CYCLES=2); Data_BUS_READ = 32'hCAFE_0001; ERR = 0.
//  2 Write 32'h0000_00A5 to IO_BASE.
//    -> IO_OUT = 32'h0000_00A5 after DONE; the RAM word at index 0 is unchanged.
//  3 Read ADDR 0x13 (misaligned), then read 0x0001_0000 (out of range).
//    -> ERR = 1 and Data_BUS_READ = 0 after each; a following valid read clears ERR.
//  4 Start a write to 0x20 and drop CS in cycle 1 (WAIT).
//    -> no DONE pulse; a later read of 0x20 returns the old value.
//  5 Assert RST=0 mid-WAIT of a write.
//    -> all outputs read 0 immediately (asynchronously); the write is not committed.
//  6 Hold CS high for 34 cycles, then change ADDR 0x10 -> 0x14 with CS still high.
//    -> exactly two DONE pulses.

Source files
------------

// File: rtl/bus_mem_ctrl.sv
// rtl/bus_mem_ctrl.sv - word-addressed data RAM slave with IO_OUT register and programmable wait states
module bus_mem_ctrl #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic        WR_RD,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    output logic [31:0] Data_BUS_READ,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] IO_OUT
);

    localparam int          DEPTH     = 2 ** ADDR_WIDTH;
    // One past the last RAM byte address; 33 bits so a 2**30-word RAM still fits
    localparam logic [32:0] RAM_LIMIT = 33'(DEPTH) << 2;
    // Wait counter counts down from WAIT_CYCLES-1 to 0, so WAIT lasts WAIT_CYCLES cycles
    localparam logic [4:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 5'(WAIT_CYCLES - 1) : 5'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t                  state;
    logic [4:0]              wait_cnt;
    logic                    cs_prev;
    logic [32:0]             last_req;
    logic [31:0]             lat_addr;
    logic                    lat_wr;
    logic [31:0]             lat_data;

    logic                    accept;
    logic                    misaligned;
    logic                    io_hit;
    logic                    ram_hit;
    logic                    fault;
    logic [ADDR_WIDTH-1:0]   ram_idx;
    logic [31:0]             rd_data;
    logic                    ram_wr_en;

    logic [31:0]             mem [DEPTH];

    // A new request needs a CS rising edge or a different {ADDR, WR_RD} than the last one taken;
    // a bus held steady with CS high must not start a second access
    always_comb begin
        accept = CS && (!cs_prev || ({ADDR, WR_RD} != last_req));
    end

    // Address decode of the latched request; misalignment wins over every other region
    always_comb begin
        misaligned = (lat_addr[1:0] != 2'b00);
        io_hit     = !misaligned && (lat_addr == IO_BASE);
        ram_hit    = !misaligned && !io_hit && ({1'b0, lat_addr} < RAM_LIMIT);
        fault      = !(io_hit || ram_hit);
        ram_idx    = lat_addr[ADDR_WIDTH+1:2];
        ram_wr_en  = (state == S_ACCESS) && lat_wr && ram_hit;
    end

    // Read data mux; faulted reads return zero rather than whatever the array holds
    always_comb begin
        rd_data = 32'h0000_0000;
        if (io_hit) begin
            rd_data = IO_OUT;
        end else if (ram_hit) begin
            rd_data = mem[ram_idx];
        end
    end

    // RAM array write port; contents deliberately survive reset
    always_ff @(posedge CLK) begin
        if (ram_wr_en) begin
            mem[ram_idx] <= lat_data;
        end
    end

    // Access sequencer: IDLE -> WAIT -> ACCESS -> DONE with all bus outputs registered
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= S_IDLE;
            wait_cnt      <= 5'd0;
            cs_prev       <= 1'b0;
            last_req      <= 33'd0;
            lat_addr      <= 32'h0000_0000;
            lat_wr        <= 1'b0;
            lat_data      <= 32'h0000_0000;
            Data_BUS_READ <= 32'h0000_0000;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ERR           <= 1'b0;
            IO_OUT        <= 32'h0000_0000;
        end else begin
            cs_prev <= CS;
            DONE    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_addr <= ADDR;
                        lat_wr   <= WR_RD;
                        lat_data <= Data_BUS_WRITE;
                        last_req <= {ADDR, WR_RD};
                        BUSY     <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_ACCESS;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LAST;
                        end
                    end
                end
                S_WAIT: begin
                    // The cpu withdrawing CS before the array is touched cancels the access silently
                    if (!CS) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end else if (wait_cnt == 5'd0) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 5'd1;
                    end
                end
                S_ACCESS: begin
                    // Past this point the access is committed regardless of CS
                    state <= S_DONE;
                    DONE  <= 1'b1;
                    ERR   <= fault;
                    if (!lat_wr) begin
                        Data_BUS_READ <= rd_data;
                    end else if (io_hit) begin
                        IO_OUT <= lat_data;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// tb/tb_bus_mem_ctrl.sv - scoreboard bench for bus_mem_ctrl with randomized accesses
module tb_bus_mem_ctrl;

    localparam int          AW     = 10;
    localparam int          W      = 2;
    localparam logic [31:0] IO_A   = 32'hFFFF_FF00;
    localparam int          NBYTES = 4 * (2 ** AW);

    logic        CLK;
    logic        RST;
    logic        CS;
    logic        WR_RD;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [31:0] IO_OUT;

    bus_mem_ctrl #(
        .ADDR_WIDTH (AW),
        .WAIT_CYCLES(W),
        .IO_BASE    (IO_A)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .CS            (CS),
        .WR_RD         (WR_RD),
        .ADDR          (ADDR),
        .Data_BUS_WRITE(Data_BUS_WRITE),
        .Data_BUS_READ (Data_BUS_READ),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERR           (ERR),
        .IO_OUT        (IO_OUT)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
        logic [31:0] io;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [int];
    logic [31:0] rd_ref;
    logic        err_ref;
    logic [31:0] io_ref;

    int checks = 0;
    int passed = 0;
    int n_done = 0;
    int cyc    = 0;

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference behaviour: what the cpu should observe after the access completes
    function automatic void model_access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        bit io;
        bit flt;
        io  = (addr == IO_A);
        flt = (addr[1:0] != 2'b00) || (!io && addr >= 32'(NBYTES));
        err_ref = flt;
        if (wr) begin
            if (!flt) begin
                if (io) io_ref = data;
                else    ref_mem[int'(addr >> 2)] = data;
            end
        end else begin
            if (flt)     rd_ref = 32'h0;
            else if (io) rd_ref = io_ref;
            else         rd_ref = ref_mem[int'(addr >> 2)];
        end
    endfunction

    // Monitor: every DONE pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1 && DONE === 1'b1) begin
                n_done++;
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: DONE=1 with no access outstanding, required 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("read_data", Data_BUS_READ, e.rd);
                    check("err", {31'b0, ERR}, {31'b0, e.err});
                    check("io_out", IO_OUT, e.io);
                end
            end
        end
    end

    // One full access; keeps CS high for 'hold' idle cycles afterwards, then drops it if asked
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input int hold, input bit drop);
        int start;
        int target;
        @(negedge CLK);
        CS = 1'b1;
        WR_RD = wr;
        ADDR = addr;
        Data_BUS_WRITE = data;
        start = cyc;
        model_access(wr, addr, data);
        sb.push_back('{start + W + 2, rd_ref, err_ref, io_ref});
        target = n_done + 1;
        @(negedge CLK);
        #1;
        check("busy_start", {31'b0, BUSY}, 32'd1);
        for (int i = 0; i < 40 && n_done < target; i++) begin
            @(negedge CLK);
            #1;
        end
        if (n_done < target) begin
            checks++;
            $display("FAIL done_timeout: no DONE within 40 cycles, required one (addr %h)", addr);
        end
        @(negedge CLK);
        #1;
        check("busy_end", {31'b0, BUSY}, 32'd0);
        repeat (hold) @(negedge CLK);
        if (drop) CS = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          k;
        int          d0;
        RST = 1'b0;
        CS = 1'b0;
        WR_RD = 1'b0;
        ADDR = 32'h0;
        Data_BUS_WRITE = 32'h0;
        rd_ref = 32'h0;
        err_ref = 1'b0;
        io_ref = 32'h0;
        #5;
        check("rst_read", Data_BUS_READ, 32'h0);
        check("rst_busy", {31'b0, BUSY}, 32'd0);
        check("rst_done", {31'b0, DONE}, 32'd0);
        check("rst_err", {31'b0, ERR}, 32'd0);
        check("rst_io", IO_OUT, 32'h0);
        @(negedge CLK);
        RST = 1'b1;

        // Initialise a small pool of RAM words so every later read has a known value
        for (int i = 0; i < 16; i++) access(1'b1, 32'(i * 4), $urandom, 0, 1'b1);

        // Write then read back a word
        access(1'b1, 32'h10, 32'hCAFE_0001, 0, 1'b1);
        access(1'b0, 32'h10, 32'h0, 0, 1'b1);

        // IO register write, RAM word 0 left alone
        access(1'b1, IO_A, 32'h0000_00A5, 1, 1'b1);
        access(1'b0, 32'h0, 32'h0, 0, 1'b1);
        access(1'b0, IO_A, 32'h0, 0, 1'b1);

        // Faulting reads followed by a clean one
        access(1'b0, 32'h13, 32'h0, 0, 1'b1);
        access(1'b0, 32'h0001_0000, 32'h0, 0, 1'b1);
        access(1'b0, 32'h10, 32'h0, 0, 1'b1);
        access(1'b0, 32'h0000_0FFC, 32'h0, 0, 1'b1);
        access(1'b1, 32'h0000_1000, 32'h1234_5678, 0, 1'b1);

        // CS withdrawn in WAIT: no DONE, no commit
        @(negedge CLK);
        CS = 1'b1;
        WR_RD = 1'b1;
        ADDR = 32'h20;
        Data_BUS_WRITE = 32'hDEAD_BEEF;
        @(negedge CLK);
        CS = 1'b0;
        @(negedge CLK);
        #1;
        check("abort_busy", {31'b0, BUSY}, 32'd0);
        repeat (6) @(negedge CLK);
        access(1'b0, 32'h20, 32'h0, 0, 1'b1);

        // Asynchronous reset in the middle of a write's WAIT phase
        access(1'b1, IO_A, 32'h5A5A_0F0F, 0, 1'b1);
        access(1'b0, 32'h24, 32'h0, 0, 1'b1);
        @(negedge CLK);
        CS = 1'b1;
        WR_RD = 1'b1;
        ADDR = 32'h24;
        Data_BUS_WRITE = 32'h0BAD_0BAD;
        @(negedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check("arst_read", Data_BUS_READ, 32'h0);
        check("arst_busy", {31'b0, BUSY}, 32'd0);
        check("arst_done", {31'b0, DONE}, 32'd0);
        check("arst_err", {31'b0, ERR}, 32'd0);
        check("arst_io", IO_OUT, 32'h0);
        rd_ref = 32'h0;
        err_ref = 1'b0;
        io_ref = 32'h0;
        @(negedge CLK);
        CS = 1'b0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        access(1'b0, 32'h24, 32'h0, 0, 1'b1);

        // CS held high across a long steady bus, then an address change
        d0 = n_done;
        access(1'b0, 32'h10, 32'h0, 34, 1'b0);
        access(1'b0, 32'h14, 32'h0, 0, 1'b1);
        check("held_cs_pulses", 32'(n_done - d0), 32'd2);

        // Randomized mix of pool, IO, misaligned and out-of-range accesses
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15)) << 2;
            if (k == 6)      a = IO_A;
            else if (k == 7) a = a | 32'($urandom_range(1, 3));
            else if (k == 8) a = 32'h0000_1000 | ($urandom & 32'h7FFF_FFFC);
            access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), 1'b1);
        end

        repeat (4) @(negedge CLK);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
